// File: rtl/pd_power_seq_ctrl.sv
// rtl/pd_power_seq_ctrl.sv - power-domain sequencing controller
// Orders clock gate, isolation, retention strobes and power switch; flags power-switch ack timeouts.
module pd_power_seq_ctrl #(
  parameter int CLK_GAP        = 2,
  parameter int ISO_SETUP      = 2,
  parameter int SAVE_CYCLES    = 1,
  parameter int RESTORE_CYCLES = 1,
  parameter int ACK_TIMEOUT    = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       pwr_down_req,
  input  logic       pwr_up_req,
  input  logic       pwr_ack,
  output logic       clk_en,
  output logic       iso_en,
  output logic       save,
  output logic       restore,
  output logic       pwr_en,
  output logic       pd_off,
  output logic       busy,
  output logic       err,
  output logic [3:0] state_o
);

  localparam int MAX_A = (CLK_GAP > ISO_SETUP) ? CLK_GAP : ISO_SETUP;
  localparam int MAX_B = (SAVE_CYCLES > RESTORE_CYCLES) ? SAVE_CYCLES : RESTORE_CYCLES;
  localparam int MAX_C = (MAX_A > MAX_B) ? MAX_A : MAX_B;
  localparam int MAX_P = (MAX_C > ACK_TIMEOUT) ? MAX_C : ACK_TIMEOUT;
  localparam int CNT_W = $clog2(MAX_P + 1);

  // A timed state of length N exits when the counter, cleared on entry, reaches N-1.
  localparam logic [CNT_W-1:0] GAP_LAST = CNT_W'(CLK_GAP - 1);
  localparam logic [CNT_W-1:0] ISO_LAST = CNT_W'(ISO_SETUP - 1);
  localparam logic [CNT_W-1:0] SAV_LAST = CNT_W'(SAVE_CYCLES - 1);
  localparam logic [CNT_W-1:0] RST_LAST = CNT_W'(RESTORE_CYCLES - 1);
  localparam logic [CNT_W-1:0] ACK_LAST = CNT_W'(ACK_TIMEOUT - 1);

  typedef enum logic [3:0] {
    ST_ON        = 4'd0,
    ST_CLK_STOP  = 4'd1,
    ST_ISO_ON    = 4'd2,
    ST_SAVE      = 4'd3,
    ST_PD_WAIT   = 4'd4,
    ST_OFF       = 4'd5,
    ST_PU_WAIT   = 4'd6,
    ST_RESTORE   = 4'd7,
    ST_ISO_REL   = 4'd8,
    ST_CLK_START = 4'd9,
    ST_ERR       = 4'd10
  } state_e;

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [7:0]       outs_q, outs_d;

  // Output word: {clk_en, iso_en, save, restore, pwr_en, pd_off, busy, err}
  function automatic logic [7:0] decode(input state_e s);
    case (s)
      ST_ON:        decode = 8'b1000_1000;
      ST_CLK_STOP:  decode = 8'b0000_1010;
      ST_ISO_ON:    decode = 8'b0100_1010;
      ST_SAVE:      decode = 8'b0110_1010;
      ST_PD_WAIT:   decode = 8'b0100_0010;
      ST_OFF:       decode = 8'b0100_0100;
      ST_PU_WAIT:   decode = 8'b0100_1010;
      ST_RESTORE:   decode = 8'b0101_1010;
      ST_ISO_REL:   decode = 8'b0000_1010;
      ST_CLK_START: decode = 8'b0000_1010;
      ST_ERR:       decode = 8'b0100_0001;
      default:      decode = 8'b1000_1000;
    endcase
  endfunction

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_ON;
      cnt_q   <= '0;
      outs_q  <= decode(ST_ON);
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      outs_q  <= outs_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_ON:        if (pwr_down_req) state_d = ST_CLK_STOP;
      ST_CLK_STOP:  if (cnt_q == GAP_LAST) state_d = ST_ISO_ON;
      ST_ISO_ON:    if (cnt_q == ISO_LAST) state_d = ST_SAVE;
      ST_SAVE:      if (cnt_q == SAV_LAST) state_d = ST_PD_WAIT;
      // Ack is checked before the timeout so an ack on the final edge wins.
      ST_PD_WAIT: begin
        if (!pwr_ack)               state_d = ST_OFF;
        else if (cnt_q == ACK_LAST) state_d = ST_ERR;
      end
      ST_OFF:       if (pwr_up_req) state_d = ST_PU_WAIT;
      ST_PU_WAIT: begin
        if (pwr_ack)                state_d = ST_RESTORE;
        else if (cnt_q == ACK_LAST) state_d = ST_ERR;
      end
      ST_RESTORE:   if (cnt_q == RST_LAST) state_d = ST_ISO_REL;
      ST_ISO_REL:   if (cnt_q == ISO_LAST) state_d = ST_CLK_START;
      ST_CLK_START: if (cnt_q == GAP_LAST) state_d = ST_ON;
      ST_ERR:       state_d = ST_ERR;
      default:      state_d = ST_ON;
    endcase

    if ((state_d != state_q) || (state_q inside {ST_ON, ST_OFF, ST_ERR})) begin
      cnt_d = '0;
    end else begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  always_comb begin
    outs_d = decode(state_d);
  end

  assign {clk_en, iso_en, save, restore, pwr_en, pd_off, busy, err} = outs_q;
  assign state_o = state_q;

endmodule

// File: tb/tb_pd_power_seq_ctrl.sv
// tb/tb_pd_power_seq_ctrl.sv - bench for pd_power_seq_ctrl
// Vector table, directed corner sequences and random traffic against a segment-queue model.
module tb_pd_power_seq_ctrl;

  localparam int CLK_GAP        = 2;
  localparam int ISO_SETUP      = 2;
  localparam int SAVE_CYCLES    = 1;
  localparam int RESTORE_CYCLES = 1;
  localparam int ACK_TIMEOUT    = 16;

  // {clk_en, iso_en, save, restore, pwr_en, pd_off, busy, err}
  localparam logic [7:0] W_ON  = 8'b1000_1000;
  localparam logic [7:0] W_CS  = 8'b0000_1010;
  localparam logic [7:0] W_IO  = 8'b0100_1010;
  localparam logic [7:0] W_SV  = 8'b0110_1010;
  localparam logic [7:0] W_PDW = 8'b0100_0010;
  localparam logic [7:0] W_OFF = 8'b0100_0100;
  localparam logic [7:0] W_PUW = 8'b0100_1010;
  localparam logic [7:0] W_RS  = 8'b0101_1010;
  localparam logic [7:0] W_ERR = 8'b0100_0001;

  logic clk, rst, down, up, ack;
  logic clk_en, iso_en, save, restore, pwr_en, pd_off, busy, err;
  logic [3:0] state_o;
  logic [7:0] outs;
  int total = 0;
  int bad = 0;

  pd_power_seq_ctrl #(
    .CLK_GAP(CLK_GAP), .ISO_SETUP(ISO_SETUP), .SAVE_CYCLES(SAVE_CYCLES),
    .RESTORE_CYCLES(RESTORE_CYCLES), .ACK_TIMEOUT(ACK_TIMEOUT)
  ) dut (
    .clk(clk), .rst(rst), .pwr_down_req(down), .pwr_up_req(up), .pwr_ack(ack),
    .clk_en(clk_en), .iso_en(iso_en), .save(save), .restore(restore), .pwr_en(pwr_en),
    .pd_off(pd_off), .busy(busy), .err(err), .state_o(state_o)
  );

  assign outs = {clk_en, iso_en, save, restore, pwr_en, pd_off, busy, err};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Model: fixed-length phases are a queue of output words; only waits and idle modes are tracked.
  typedef enum {M_ON, M_SEQ, M_PDW, M_OFF, M_PUW, M_ERR} mmode_e;
  mmode_e     m_mode, m_after;
  logic [7:0] m_cur;
  logic [7:0] m_q[$];
  int         m_wc;

  function automatic logic [7:0] mode_word(input mmode_e m);
    case (m)
      M_PDW:   return W_PDW;
      M_OFF:   return W_OFF;
      M_PUW:   return W_PUW;
      M_ERR:   return W_ERR;
      default: return W_ON;
    endcase
  endfunction

  function automatic void enter(input mmode_e m);
    m_mode = m;
    m_wc   = 0;
    m_cur  = mode_word(m);
  endfunction

  function automatic void start_segments(input bit is_down);
    m_q.delete();
    if (is_down) begin
      for (int i = 0; i < CLK_GAP; i++)     m_q.push_back(W_CS);
      for (int i = 0; i < ISO_SETUP; i++)   m_q.push_back(W_IO);
      for (int i = 0; i < SAVE_CYCLES; i++) m_q.push_back(W_SV);
      m_after = M_PDW;
    end else begin
      for (int i = 0; i < RESTORE_CYCLES; i++) m_q.push_back(W_RS);
      for (int i = 0; i < ISO_SETUP; i++)      m_q.push_back(W_CS);
      for (int i = 0; i < CLK_GAP; i++)        m_q.push_back(W_CS);
      m_after = M_ON;
    end
    m_mode = M_SEQ;
    m_cur  = m_q.pop_front();
  endfunction

  function automatic void model_step();
    if (rst) begin
      m_q.delete();
      enter(M_ON);
    end else begin
      case (m_mode)
        M_ON:  if (down) start_segments(1'b1);
        M_SEQ: if (m_q.size() > 0) m_cur = m_q.pop_front(); else enter(m_after);
        M_PDW: begin
          m_wc++;
          if (!ack) enter(M_OFF);
          else if (m_wc == ACK_TIMEOUT) enter(M_ERR);
        end
        M_OFF: if (up) enter(M_PUW);
        M_PUW: begin
          m_wc++;
          if (ack) start_segments(1'b0);
          else if (m_wc == ACK_TIMEOUT) enter(M_ERR);
        end
        default: ;
      endcase
    end
  endfunction

  task automatic check_outs(input string nm, input logic [7:0] exp);
    total++;
    if (outs !== exp) begin
      bad++;
      $display("FAIL %s: outs got %b want %b at %0t", nm, outs, exp, $time);
    end
  endtask

  task automatic tick(input string nm);
    @(posedge clk);
    model_step();
    @(negedge clk);
    check_outs({"model_", nm}, m_cur);
    total++;
    assert ((iso_en || pwr_en) && !(iso_en && clk_en) && !(save && restore) && !(save && !pwr_en))
    else begin
      bad++;
      $display("FAIL invariant_%s: outs got %b at %0t", nm, outs, $time);
    end
  endtask

  task automatic cyc(input logic r, input logic d, input logic u, input logic a, input string nm);
    rst  = r;
    down = d;
    up   = u;
    ack  = a;
    tick(nm);
  endtask

  task automatic do_reset();
    cyc(1'b1, 1'b0, 1'b0, 1'b1, "reset");
  endtask

  typedef struct {
    logic r, d, u, a;
    logic [7:0] exp;
  } vec_t;
  vec_t vecs[$];

  function automatic void add_vec(input logic r, d, u, a, input logic [7:0] e);
    vec_t v;
    v.r = r; v.d = d; v.u = u; v.a = a; v.exp = e;
    vecs.push_back(v);
  endfunction

  bit   stuck;
  logic stuck_val;
  logic ra, rd, ru, rr;

  initial begin
    rst = 1'b1; down = 1'b0; up = 1'b0; ack = 1'b1;
    m_mode = M_ON; m_after = M_ON; m_cur = W_ON; m_wc = 0;

    // Reset, full power-down with ack dropping late, power-up, ignored up request in ON
    add_vec(1, 0, 0, 1, W_ON);
    add_vec(0, 1, 0, 1, W_CS);
    add_vec(0, 0, 0, 1, W_CS);
    add_vec(0, 0, 0, 1, W_IO);
    add_vec(0, 0, 0, 1, W_IO);
    add_vec(0, 0, 0, 1, W_SV);
    add_vec(0, 0, 0, 1, W_PDW);
    add_vec(0, 0, 0, 1, W_PDW);
    add_vec(0, 0, 0, 0, W_OFF);
    add_vec(0, 1, 0, 0, W_OFF);
    add_vec(0, 0, 1, 0, W_PUW);
    add_vec(0, 0, 0, 0, W_PUW);
    add_vec(0, 0, 0, 1, W_RS);
    add_vec(0, 0, 0, 1, W_CS);
    add_vec(0, 0, 0, 1, W_CS);
    add_vec(0, 0, 0, 1, W_CS);
    add_vec(0, 0, 0, 1, W_CS);
    add_vec(0, 0, 0, 1, W_ON);
    add_vec(0, 0, 1, 1, W_ON);
    add_vec(0, 0, 0, 0, W_ON);
    for (int i = 0; i < vecs.size(); i++) begin
      cyc(vecs[i].r, vecs[i].d, vecs[i].u, vecs[i].a, "vec");
      check_outs($sformatf("vec%0d", i), vecs[i].exp);
    end

    // Down timeout with ack stuck high, sticky error, reset recovery
    do_reset();
    cyc(0, 1, 0, 1, "t3");
    for (int k = 2; k <= 21; k++) cyc(0, 0, 0, 1, "t3");
    check_outs("t3_pdwait_e21", W_PDW);
    cyc(0, 0, 0, 1, "t3");
    check_outs("t3_err_e22", W_ERR);
    for (int k = 0; k < 6; k++) cyc(0, (k % 2 == 0), (k % 2 == 1), (k % 3 == 0), "t3_req");
    check_outs("t3_err_sticky", W_ERR);
    cyc(1, 0, 0, 1, "t3_rst");
    check_outs("t3_rst_on", W_ON);

    // Ack falls exactly on the timeout edge
    do_reset();
    cyc(0, 1, 0, 1, "t4");
    for (int k = 2; k <= 21; k++) cyc(0, 0, 0, 1, "t4");
    cyc(0, 0, 0, 0, "t4");
    check_outs("t4_boundary_off", W_OFF);

    // Reset while in SAVE
    do_reset();
    cyc(0, 1, 0, 1, "t5");
    for (int k = 2; k <= 5; k++) cyc(0, 0, 0, 1, "t5");
    check_outs("t5_in_save", W_SV);
    cyc(1, 0, 0, 1, "t5_rst");
    check_outs("t5_rst_on", W_ON);
    cyc(0, 0, 0, 1, "t5");
    check_outs("t5_stay_on", W_ON);

    // Up request in ON ignored; down pulses mid-sequence ignored
    do_reset();
    for (int k = 1; k <= 3; k++) cyc(0, 0, 1, 1, "t6a");
    check_outs("t6a_up_in_on", W_ON);
    cyc(0, 1, 0, 1, "t6a");
    cyc(0, 0, 0, 1, "t6a");
    cyc(0, 1, 0, 1, "t6a");
    check_outs("t6a_iso_on", W_IO);
    cyc(0, 1, 0, 1, "t6a");
    cyc(0, 0, 0, 1, "t6a");
    check_outs("t6a_save", W_SV);
    cyc(0, 0, 0, 1, "t6a");
    check_outs("t6a_pdwait", W_PDW);

    // Down request held high retriggers one edge after ON
    do_reset();
    for (int k = 1; k <= 6; k++) cyc(0, 1, 0, 1, "t6b");
    cyc(0, 1, 0, 0, "t6b");
    check_outs("t6b_off_down_held", W_OFF);
    cyc(0, 1, 1, 0, "t6b");
    for (int k = 9; k <= 13; k++) cyc(0, 1, 0, 1, "t6b");
    cyc(0, 1, 0, 1, "t6b");
    check_outs("t6b_on", W_ON);
    cyc(0, 1, 0, 1, "t6b");
    check_outs("t6b_retrigger", W_CS);

    // Random traffic; ack mostly follows pwr_en with occasional stuck phases
    do_reset();
    stuck = 0;
    stuck_val = 1'b0;
    for (int i = 0; i < 3000; i++) begin
      if (i % 64 == 0) begin
        stuck     = ($urandom_range(0, 3) == 0);
        stuck_val = 1'($urandom_range(0, 1));
      end
      rr = ($urandom_range(0, 249) == 0);
      rd = ($urandom_range(0, 3) == 0);
      ru = ($urandom_range(0, 3) == 0);
      if (stuck) ra = stuck_val;
      else if ($urandom_range(0, 4) != 0) ra = m_cur[3];
      else ra = 1'($urandom_range(0, 1));
      cyc(rr, rd, ru, ra, "rand");
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/pd_power_seq_ctrl.md
Name: pd_power_seq_ctrl

Overview:
Power-sequencing controller for one switchable power domain. It sits directly upstream of the domain's isolation cells and retention flops. It produces the clock-gate enable, iso_en, save/restore strobes and power-switch enable in the mandatory order for power-down and power-up. It handshakes with the power switch through pwr_ack and flags a sticky error if the switch fails to respond.

Parameters:
CLK_GAP, 2, cycles clk_en is held low before iso_en asserts, and cycles held after iso_en deasserts before returning to ON (min 1)
ISO_SETUP, 2, cycles iso_en is held before save, and before clock restart on power-up (min 1)
SAVE_CYCLES, 1, width of save pulse in cycles (min 1)
RESTORE_CYCLES, 1, width of restore pulse in cycles (min 1)
ACK_TIMEOUT, 16, max cycles to wait for pwr_ack in a wait state (min 1)
CNT_W, $clog2 of max(all above)+1, internal counter width (derived, not overridden)

Ports:
clk  input  1  block clock; single clock domain
rst  input  1  synchronous, active-high reset
pwr_down_req  input  1  level request to power domain down; sampled only in ON
pwr_up_req  input  1  level request to power domain up; sampled only in OFF
pwr_ack  input  1  power-switch status, 1 = domain rail good; synchronous to clk
clk_en  output  1  domain clock-gate enable
iso_en  output  1  to isolation cells, 1 = isolate
save  output  1  retention save strobe
restore  output  1  retention restore strobe
pwr_en  output  1  power-switch enable, 1 = rail on
pd_off  output  1  1 when state is OFF
busy  output  1  1 in any state other than ON, OFF, ERR
err  output  1  sticky timeout error
state_o  output  4  current state encoding, for debug

Behaviour:
- Reset: one clock, synchronous, active-high. rst sampled high at any edge → state ON, counter 0.
  - Outputs after reset: clk_en=1, iso_en=0, save=0, restore=0, pwr_en=1, pd_off=0, busy=0, err=0.
  - rst mid-sequence (including ERR) aborts immediately to ON.
- All outputs are registered (Moore, decoded from the state register) and glitch-free. An output changes on the edge that enters its state.
- Timed states: entered at edge e, last exactly N cycles, exit at edge e+N. The counter is reset on every state entry.
- States and outputs (clk_en, iso_en, save, restore, pwr_en):
  - ON: 1,0,0,0,1. Leaves to CLK_STOP when pwr_down_req=1 at an edge.
  - CLK_STOP: 0,0,0,0,1. Lasts CLK_GAP, then ISO_ON.
  - ISO_ON: 0,1,0,0,1. Lasts ISO_SETUP, then SAVE.
  - SAVE: 0,1,1,0,1. Lasts SAVE_CYCLES, then PD_WAIT.
  - PD_WAIT: 0,1,0,0,0. Goes to OFF at the first edge with pwr_ack=0. Minimum dwell is 1 cycle, even if ack is already 0.
  - OFF: 0,1,0,0,0. pd_off=1. Leaves to PU_WAIT when pwr_up_req=1.
  - PU_WAIT: 0,1,0,0,1. Goes to RESTORE at the first edge with pwr_ack=1. Minimum dwell is 1 cycle.
  - RESTORE: 0,1,0,1,1. Lasts RESTORE_CYCLES, then ISO_REL.
  - ISO_REL: 0,0,0,0,1. Lasts ISO_SETUP, then CLK_START.
  - CLK_START: 0,0,0,0,1. Lasts CLK_GAP, then ON, where clk_en=1.
  - ERR: 0,1,0,0,0. err=1. Exits only by rst.
- Timeout in PD_WAIT/PU_WAIT: the counter increments each cycle in the state.
  - If the required pwr_ack level has not been seen by the ACK_TIMEOUT-th edge in the state → ERR.
  - If ack arrives on that same edge, ack wins and there is no error.
- Request rules:
  - Requests are ignored outside ON (down) and OFF (up).
  - pwr_up_req in ON is ignored. pwr_down_req in OFF is ignored.
  - A request held high through completion retriggers: e.g. a down request still high when ON is re-entered starts a new power-down on the next edge.
- pwr_ack glitches outside the wait states are ignored.
- Invariants (assert in bench):
  - iso_en=1 whenever pwr_en=0.
  - clk_en=0 whenever iso_en=1.
  - save and restore are never both 1.
  - save=1 implies pwr_en=1.
- Full down sequence latency with defaults and immediate ack: req edge 0 → OFF at edge 7.

Test Plan:
1. Power-down with defaults: pwr_down_req=1 at edge 0, pwr_ack drops 2 cycles after pwr_en falls → expected outputs:
   - clk_en=0 at edge 1
   - iso_en=1 at edge 3
   - save=1 for edge 5 only
   - pwr_en=0 at edge 6
   - pd_off=1 at edge 8
   - invariants hold throughout.
2. Power-up from OFF: pwr_up_req=1 at edge 0, pwr_ack=1 one cycle after pwr_en rises → expected outputs:
   - pwr_en=1 at edge 1
   - restore=1 for edge 3 only
   - iso_en=0 at edge 4
   - clk_en=1 at edge 8
   - busy low at edge 8.
3. Down timeout: pwr_ack held 1 forever → expected: ERR 16 edges after PD_WAIT entry; err=1, iso_en=1, pwr_en=0, clk_en=0; further requests ignored. rst then returns ON with err=0.
4. Ack on the timeout boundary: pwr_ack falls exactly on the 16th edge in PD_WAIT → expected: OFF, err=0.
5. Reset mid-sequence: rst=1 while in SAVE → expected: next edge state ON with clk_en=1, iso_en=0, save=0, pwr_en=1.
6. Request filtering:
   - pwr_up_req=1 in ON and pwr_down_req pulses during ISO_ON → no effect on the sequence.
   - pwr_down_req held high → a second power-down starts one edge after ON is reached.
